// File: rtl/axi_aw_arb_monitor_if.sv
// axi_aw_arb_monitor_if: per-channel AXI write-address valid/ready bundle
interface axi_aw_arb_monitor_if #(parameter int NUM_CH = 3);
    logic [NUM_CH-1:0] awvalid;
    logic [NUM_CH-1:0] awready;
    modport master (output awvalid, input awready);
    modport slave (input awvalid, output awready);
    modport monitor (input awvalid, input awready);
endinterface

// File: rtl/axi_aw_arb_monitor.sv
// axi_aw_arb_monitor: passive AW arbiter compliance checker; optional SVA via AXI_ARB_MON_ASSERT_EN
module axi_aw_arb_monitor #(
    parameter int NUM_CH = 3,
    parameter int CNT_W = 17,
    parameter int WEIGHT_W = 16,
    parameter int STARVE_W = 16,
    parameter int VCNT_W = 16,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    axi_aw_arb_monitor_if.monitor      aw,
    input  logic                       arb_en,
    input  logic [1:0]                 arb_mode,
    input  logic [NUM_CH*WEIGHT_W-1:0] weight,
    input  logic [STARVE_W-1:0]        starve_limit,
    input  logic                       clr_err,
    output logic                       err_valid,
    output logic [2:0]                 err_code,
    output logic [CH_W-1:0]            err_ch,
    output logic [4:0]                 err_sticky,
    output logic [VCNT_W-1:0]          viol_cnt
);
    localparam int CMP_W = CNT_W > WEIGHT_W ? CNT_W : WEIGHT_W;
    logic [NUM_CH-1:0] hs;
    logic [NUM_CH-1:0] awvalid_dly;
    logic [CNT_W-1:0] streak [NUM_CH];
    logic [STARVE_W-1:0] wait_cnt [NUM_CH];
    logic [4:0] fire;
    logic [CH_W-1:0] fire_ch [5];
    logic multi;
    logic [2:0] code_sel;
    logic [CH_W-1:0] ch_sel;
    assign hs = aw.awvalid & aw.awready;
    assign multi = (hs & (hs - NUM_CH'(1))) != '0;
    // rule checks on pre-update history; descending scan leaves the lowest channel per code
    always_comb begin
        fire = '0;
        for (int k = 0; k < 5; k++) fire_ch[k] = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (multi && hs[i]) begin
                fire[0] = 1'b1;
                fire_ch[0] = CH_W'(i);
            end
            if (i >= 1 && !arb_en && hs[i]) begin
                fire[1] = 1'b1;
                fire_ch[1] = CH_W'(i);
            end
            if (arb_en && arb_mode == 2'd0 && hs[i] && (aw.awvalid & ((NUM_CH'(1) << i) - NUM_CH'(1))) != '0) begin
                fire[2] = 1'b1;
                fire_ch[2] = CH_W'(i);
            end
            if (arb_en && hs[i] && (awvalid_dly & ~(NUM_CH'(1) << i)) != '0 &&
                ((arb_mode == 2'd1 && streak[i] > CNT_W'(1)) ||
                 (arb_mode == 2'd2 && CMP_W'(streak[i]) > CMP_W'(weight[i*WEIGHT_W +: WEIGHT_W])))) begin
                fire[3] = 1'b1;
                fire_ch[3] = CH_W'(i);
            end
            if (starve_limit != '0 && wait_cnt[i] >= starve_limit) begin
                fire[4] = 1'b1;
                fire_ch[4] = CH_W'(i);
            end
        end
    end
    assign code_sel = fire[0] ? 3'd0 : fire[1] ? 3'd1 : fire[2] ? 3'd2 : fire[3] ? 3'd3 : 3'd4;
    assign ch_sel = fire[0] ? fire_ch[0] : fire[1] ? fire_ch[1] : fire[2] ? fire_ch[2] : fire[3] ? fire_ch[3] : fire_ch[4];
    // per-channel history: delayed valid, saturating grant streaks and wait counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awvalid_dly <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                streak[i] <= '0;
                wait_cnt[i] <= '0;
            end
        end else begin
            awvalid_dly <= aw.awvalid;
            for (int i = 0; i < NUM_CH; i++) begin
                streak[i] <= (hs[i] && arb_en) ? ((&streak[i]) ? streak[i] : streak[i] + CNT_W'(1)) :
                             ((hs & ~(NUM_CH'(1) << i)) != '0) ? '0 : streak[i];
                wait_cnt[i] <= (!aw.awvalid[i] || hs[i]) ? '0 :
                               (&wait_cnt[i]) ? wait_cnt[i] : wait_cnt[i] + STARVE_W'(1);
            end
        end
    end
    // registered reporting; a violation beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            err_code <= '0;
            err_ch <= '0;
            err_sticky <= '0;
            viol_cnt <= '0;
        end else begin
            err_valid <= |fire;
            if (|fire) begin
                err_code <= code_sel;
                err_ch <= ch_sel;
            end
            err_sticky <= (clr_err ? 5'd0 : err_sticky) | fire;
            viol_cnt <= clr_err ? VCNT_W'(|fire) :
                        (|fire && !(&viol_cnt)) ? viol_cnt + VCNT_W'(1) : viol_cnt;
        end
    end
`ifdef AXI_ARB_MON_ASSERT_EN
    for (genvar k = 0; k < 5; k++) begin : g_sva
        a_rule: assert property (@(posedge clk) disable iff (!rst_n) !fire[k])
            else $error("axi_aw_arb_monitor: violation code %0d ch %0d at %0t", k, fire_ch[k], $time);
    end
`else
`endif
endmodule

// File: tb/tb_axi_aw_arb_monitor.sv
// tb_axi_aw_arb_monitor: directed table and sequence bench for the AW arbiter monitor
module tb_axi_aw_arb_monitor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic arb_en;
    logic clr_err;
    logic [1:0] arb_mode;
    logic [47:0] weight;
    logic [15:0] starve_limit;
    logic err_valid;
    logic [2:0] err_code;
    logic [1:0] err_ch;
    logic [4:0] err_sticky;
    logic [3:0] viol_cnt;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    axi_aw_arb_monitor_if #(.NUM_CH(3)) aw ();

    axi_aw_arb_monitor #(.NUM_CH(3), .VCNT_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .aw(aw),
        .arb_en(arb_en),
        .arb_mode(arb_mode),
        .weight(weight),
        .starve_limit(starve_limit),
        .clr_err(clr_err),
        .err_valid(err_valid),
        .err_code(err_code),
        .err_ch(err_ch),
        .err_sticky(err_sticky),
        .viol_cnt(viol_cnt)
    );

    typedef struct {
        logic en;
        logic [1:0] mode;
        logic [2:0] v;
        logic [2:0] r;
        logic ev;
        logic [2:0] ec;
        logic [1:0] ech;
        logic [4:0] es;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic en, input logic [1:0] mode, input logic [2:0] v, input logic [2:0] r, input logic clr);
        arb_en = en;
        arb_mode = mode;
        aw.awvalid = v;
        aw.awready = r;
        clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid"}, 32'(err_valid), 32'd0);
        check({tag, " code"}, 32'(err_code), 32'd0);
        check({tag, " ch"}, 32'(err_ch), 32'd0);
        check({tag, " sticky"}, 32'(err_sticky), 32'd0);
        check({tag, " cnt"}, 32'(viol_cnt), 32'd0);
    endtask

    initial begin
        arb_en = 1'b0;
        arb_mode = 2'd0;
        weight = '0;
        starve_limit = '0;
        clr_err = 1'b0;
        aw.awvalid = '0;
        aw.awready = '0;
        vecs[0]  = '{1'b1, 2'd0, 3'b011, 3'b010, 1'b1, 3'd2, 2'd1, 5'b00100};
        vecs[1]  = '{1'b1, 2'd0, 3'b001, 3'b001, 1'b0, 3'd0, 2'd0, 5'b00000};
        vecs[2]  = '{1'b1, 2'd0, 3'b111, 3'b100, 1'b1, 3'd2, 2'd2, 5'b00100};
        vecs[3]  = '{1'b0, 2'd0, 3'b101, 3'b101, 1'b1, 3'd0, 2'd0, 5'b00011};
        vecs[4]  = '{1'b0, 2'd1, 3'b001, 3'b001, 1'b0, 3'd0, 2'd0, 5'b00000};
        vecs[5]  = '{1'b0, 2'd2, 3'b010, 3'b010, 1'b1, 3'd1, 2'd1, 5'b00010};
        vecs[6]  = '{1'b1, 2'd1, 3'b011, 3'b010, 1'b0, 3'd0, 2'd0, 5'b00000};
        vecs[7]  = '{1'b1, 2'd3, 3'b111, 3'b100, 1'b0, 3'd0, 2'd0, 5'b00000};
        vecs[8]  = '{1'b1, 2'd0, 3'b110, 3'b110, 1'b1, 3'd0, 2'd1, 5'b00101};
        vecs[9]  = '{1'b1, 2'd2, 3'b011, 3'b011, 1'b1, 3'd0, 2'd0, 5'b00001};
        vecs[10] = '{1'b1, 2'd0, 3'b000, 3'b111, 1'b0, 3'd0, 2'd0, 5'b00000};
        vecs[11] = '{1'b0, 2'd3, 3'b111, 3'b111, 1'b1, 3'd0, 2'd0, 5'b00011};

        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            step(1'b0, 2'd0, 3'b000, 3'b000, 1'b1);
            step(vecs[i].en, vecs[i].mode, vecs[i].v, vecs[i].r, 1'b1);
            check($sformatf("vec%0d valid", i), 32'(err_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d sticky", i), 32'(err_sticky), 32'(vecs[i].es));
            check($sformatf("vec%0d cnt", i), 32'(viol_cnt), 32'(vecs[i].ev));
            if (vecs[i].ev) begin
                check($sformatf("vec%0d code", i), 32'(err_code), 32'(vecs[i].ec));
                check($sformatf("vec%0d ch", i), 32'(err_ch), 32'(vecs[i].ech));
            end
        end

        step(1'b1, 2'd3, 3'b010, 3'b010, 1'b1);
        step(1'b0, 2'd0, 3'b000, 3'b000, 1'b1);
        for (int g = 0; g < 3; g++) begin
            step(1'b1, 2'd1, 3'b011, 3'b001, 1'b0);
            check($sformatf("rr grant%0d valid", g + 1), 32'(err_valid), 32'(g == 2));
        end
        check("rr code", 32'(err_code), 32'd3);
        check("rr ch", 32'(err_ch), 32'd0);
        check("rr sticky", 32'(err_sticky), 32'b01000);
        check("rr cnt", 32'(viol_cnt), 32'd1);

        weight = {16'd0, 16'd3, 16'd0};
        step(1'b1, 2'd3, 3'b001, 3'b001, 1'b1);
        step(1'b0, 2'd0, 3'b000, 3'b000, 1'b1);
        for (int g = 0; g < 5; g++) begin
            step(1'b1, 2'd2, 3'b110, 3'b010, 1'b0);
            check($sformatf("wrr grant%0d valid", g + 1), 32'(err_valid), 32'(g == 4));
        end
        check("wrr code", 32'(err_code), 32'd3);
        check("wrr ch", 32'(err_ch), 32'd1);

        starve_limit = 16'd8;
        step(1'b0, 2'd0, 3'b000, 3'b000, 1'b1);
        for (int n = 1; n <= 12; n++) begin
            step(1'b1, 2'd0, 3'b100, 3'b000, n == 10);
            check($sformatf("starve cyc%0d valid", n), 32'(err_valid), 32'(n >= 9));
            if (n == 9) begin
                check("starve code", 32'(err_code), 32'd4);
                check("starve ch", 32'(err_ch), 32'd2);
                check("starve cnt", 32'(viol_cnt), 32'd1);
            end
            if (n == 10) begin
                check("clr+viol cnt", 32'(viol_cnt), 32'd1);
                check("clr+viol sticky", 32'(err_sticky), 32'b10000);
            end
            if (n == 11) check("post clr cnt", 32'(viol_cnt), 32'd2);
        end
        for (int n = 0; n < 20; n++) step(1'b1, 2'd0, 3'b100, 3'b000, 1'b0);
        check("sat cnt", 32'(viol_cnt), 32'd15);
        check("sat valid", 32'(err_valid), 32'd1);

        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'd1, 3'b100, 3'b000, 1'b0);
        check("post reset valid", 32'(err_valid), 32'd0);
        check("post reset cnt", 32'(viol_cnt), 32'd0);
        check("post reset sticky", 32'(err_sticky), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axi_aw_arb_monitor.md
Name: axi_aw_arb_monitor

Overview:
Synthesizable, parametrised compliance monitor for the N-channel AXI write-address arbiter. It passively observes each channel's AW valid/ready pair and the arbiter register fields, then checks five rules: single grant, disabled-arbiter behaviour, fixed priority, round-robin, and weighted round-robin. It also detects starvation. Violations are reported as an event pulse, sticky flags and a saturating count, so the monitor can sit in RTL or on an emulator next to the DDR3 register block.

Parameters:
NUM_CH, 3, number of observed AXI channels (2..16)
CNT_W, 17, width of each per-channel consecutive-grant streak counter
WEIGHT_W, 16, width of each per-channel weight field
STARVE_W, 16, width of the starvation wait counters and limit
VCNT_W, 16, width of the violation counter

Ports:
clk  in  1  clock
rst_n  in  1  reset
arb_en  in  1  arbiter enable (arb_mode[0] of the register block)
arb_mode  in  2  0 fixed priority, 1 round-robin, 2 weighted RR, 3 reserved
weight  in  NUM_CH*WEIGHT_W  per-channel weights; channel i is at [i*WEIGHT_W +: WEIGHT_W]
starve_limit  in  STARVE_W  maximum wait cycles; 0 disables the starvation check
awvalid  in  NUM_CH  per-channel AWVALID
awready  in  NUM_CH  per-channel AWREADY
clr_err  in  1  synchronous clear of err_sticky and viol_cnt
err_valid  out  1  one-cycle pulse: at least one violation was detected
err_code  out  3  highest-priority violation code for the event
err_ch  out  $clog2(NUM_CH)  channel associated with err_code
err_sticky  out  5  accumulated violation flags, bit k = code k
viol_cnt  out  VCNT_W  number of violation cycles, saturating

Behaviour:
- Reset: rst_n is asynchronous and active-low; the clock is clk. All outputs reset to 0. Streak counters, wait counters and awvalid_dly reset to 0.
- Handshake: hs[i] = awvalid[i] & awready[i].
- awvalid_dly[i]: awvalid registered by one cycle.
- streak[i]:
  - If hs[i] & arb_en: streak[i] increments, saturating at all-ones.
  - Else if any hs[j], j != i: streak[i] clears to 0.
  - Otherwise it holds.
- wait[i]:
  - Clears when awvalid[i] is low or hs[i] is high.
  - Otherwise increments, saturating.
  - Updates regardless of arb_en.
- Checks are evaluated combinationally on current-cycle values (streak and wait are pre-update):
  - Code 0, MULTI: more than one hs bit set. err_ch = lowest set index.
  - Code 1, DISABLED: !arb_en and hs[i] for some i >= 1. err_ch = i.
  - Code 2, PRIO: arb_en, mode 0, hs[j] and awvalid[i] for some i < j. err_ch = j.
  - Code 3, RR/WRR: arb_en and hs[j] and awvalid_dly[k] for some k != j, where:
    - mode 1 requires streak[j] > 1;
    - mode 2 requires streak[j] > weight[j].
    - err_ch = j.
  - Code 4, STARVE: starve_limit != 0 and wait[i] >= starve_limit. err_ch = lowest such i. Evaluated in every mode, with arb_en high or low.
  - Mode 3 applies only codes 0, 1 and 4.
- Reporting has one-cycle latency:
  - err_valid is registered and asserts the cycle after any check fires.
  - err_code/err_ch report the lowest-numbered firing code, and the lowest channel within that code.
  - When err_valid = 0, err_code/err_ch hold their previous values.
- err_sticky:
  - Sets the bit of every firing code, not only the reported one.
  - clr_err clears it. If a clear and a new violation occur in the same cycle, the new bits are set; the violation wins.
- viol_cnt:
  - Increments by 1 per violation cycle, regardless of how many codes fire.
  - Saturates at all-ones.
  - clr_err clears it to 0. If a new violation coincides with the clear, the result is 1.
- Starvation while awvalid stays high: STARVE repeats every cycle; that is intended.
- Reset asserted mid-stream: all counters and flags return to 0 immediately. After release, no check fires on stale history, because awvalid_dly = 0.

Optional Feature:
Macro AXI_ARB_MON_ASSERT_EN.
- When defined: the block adds one concurrent SVA assert per code, clocked on clk and disabled iff !rst_n. Each assert issues $error with the code, channel and $time. Logic outputs are unchanged.
- When undefined: no SVA is compiled, and the block is pure synthesizable RTL.

Test Plan:
1. NUM_CH=3, arb_en=1, mode 0. awvalid=3'b011, awready=3'b010 at cycle 10 -> err_valid=1 at cycle 11, err_code=2, err_ch=1, err_sticky=5'b00100, viol_cnt=1.
2. Mode 1, ch0 granted 3 consecutive cycles while awvalid[1]=1 throughout -> grants 1 and 2 are clean; the third grant gives err_code=3, err_ch=0.
3. Mode 2, weight={16'd0,16'd3,16'd0} (ch1 weight 3), ch1 granted 5 consecutive cycles with ch2 pending -> only the fifth grant flags code 3, err_ch=1.
4. arb_en=0, hs on ch0 and ch2 in the same cycle -> code 0 and code 1 fire; err_code=0, err_ch=0, err_sticky=5'b00011, viol_cnt increments by 1.
5. starve_limit=8, awvalid[2]=1 and awready[2]=0 for 12 cycles -> code 4 with err_ch=2 from the ninth waiting cycle onward. clr_err in the same cycle as a violation leaves viol_cnt=1 and bit 4 set.
6. Set viol_cnt to max via sustained starvation with VCNT_W=4 -> it holds at 15. Assert rst_n=0 mid-burst -> all outputs 0 asynchronously, and there is no error in the first cycle after release.
